bus_regfile_arbiter: RTL
========================

Name: bus_regfile_arbiter

Overview:
Parametrised successor to the single-master/single-slave bus top. It arbitrates N_MASTERS bus masters onto one internal register file using a valid/ready request handshake and a registered read/write response. A round-robin grant FSM serialises transactions. Each master sees its own accept strobe and response strobe.

Parameters:
N_MASTERS, 2, number of requesting masters (>=1)
DATA_W, 32, data width
ADDR_W, 5, address width
DEPTH, 32, register file entries (<= 2**ADDR_W)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
m_valid  in  N_MASTERS  per-master request valid
m_write  in  N_MASTERS  per-master write(1)/read(0)
m_addr  in  N_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  N_MASTERS*DATA_W  packed write data, master i at [i*DATA_W +: DATA_W]
m_ready  out  N_MASTERS  one-hot accept strobe
m_rvalid  out  N_MASTERS  one-hot response strobe
m_rdata  out  DATA_W  shared response data
m_err  out  1  response error, qualified by any m_rvalid
busy  out  1  FSM not in IDLE
grant_id  out  $clog2(N_MASTERS) (min 1)  index of current/last granted master

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - m_ready=0, m_rvalid=0, m_rdata=0, m_err=0, busy=0.
  - grant_id=0; internal last-grant pointer = N_MASTERS-1, so master 0 wins first.
  - All register file entries = 0. FSM = IDLE.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any m_valid is high, pick the winner round-robin, searching from last_grant+1 with wrap.
  - Latch the winner's addr/wdata/write. Pulse m_ready[winner] for exactly one cycle (the cycle after sampling). Update last_grant and grant_id. Go to EXEC.
  - With no request, stay in IDLE with all strobes low.
- EXEC:
  - If addr < DEPTH: write commits regfile[addr]=wdata; read latches regfile[addr].
  - If addr >= DEPTH: write is dropped and read data = 0. Set an error flag. Go to RESP.
- RESP:
  - Pulse m_rvalid[grant] for one cycle.
  - m_rdata = read data, or the written wdata for writes. m_err = error flag.
  - Go to IDLE.
  - m_rdata holds its value until the next RESP; m_err clears the cycle after RESP.
- Latency: request sampled at edge T -> m_ready high after T -> m_rvalid high after T+2. Throughput is one transaction per 3 cycles. Arbitration resumes in IDLE the cycle after RESP.
- Handshake:
  - A master holds m_valid, m_write, m_addr and m_wdata stable until it sees m_ready.
  - m_valid still high in the cycle after m_ready is a new request.
  - Inputs are ignored in EXEC/RESP. No request is lost; it waits.
- Simultaneous requests: exactly one grant per arbitration. A persistently requesting master is served at most once every N_MASTERS grants while others request.
- Read-after-write: a read granted after a write's RESP returns the new value.
- Reset mid-operation: the in-flight transaction is abandoned. No m_rvalid is issued. A write still in EXEC at reset is discarded, and the register file is cleared regardless.
- N_MASTERS=1: the arbiter degenerates to pass-through and grant_id stays 0.

Optional Feature:
- Macro: BUS_FIXED_PRIORITY_EN.
- Defined: arbitration is fixed priority, lowest index wins, and last_grant is unused for selection.
- Undefined (default): round-robin as above.
- Timing, handshake and error behaviour are identical in both builds.

Test Plan:
- Master 0 writes addr 5 = 0xDEADBEEF, then reads addr 5 -> m_ready[0] 1 cycle after valid; m_rvalid[0] 2 cycles later; read m_rdata=0xDEADBEEF, m_err=0.
- Masters 0 and 1 both hold valid reads for 4 transactions -> grants 0,1,0,1; grant_id toggles; each m_rvalid one-hot. With BUS_FIXED_PRIORITY_EN, master 0 always wins while its valid is held.
- Master 1 writes addr 31 with DEPTH=16 -> m_err=1 with m_rvalid[1]; a subsequent read of addr 31 -> m_rdata=0, m_err=1; entries 0..15 unchanged.
- Write 0x1234 to addr 3, then assert rst during EXEC of a write 0x5555 to addr 3 -> no m_rvalid; after reset, read addr 3 = 0; all outputs 0 while rst is high.
- Master 0 holds m_valid continuously with no other requester -> a transaction every 3 cycles; m_ready pulses exactly 3 cycles apart; busy low only 1 of every 3 cycles.

Source files
------------

// File: rtl/bus_regfile_arbiter.sv
// Multi-master register-file bus: valid/ready requests, one transaction per 3 cycles.
// Define BUS_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration (default: round-robin).
module bus_regfile_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DEPTH     = 32
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [N_MASTERS-1:0]                              m_valid,
  input  logic [N_MASTERS-1:0]                              m_write,
  input  logic [N_MASTERS*ADDR_W-1:0]                       m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]                       m_wdata,
  output logic [N_MASTERS-1:0]                              m_ready,
  output logic [N_MASTERS-1:0]                              m_rvalid,
  output logic [DATA_W-1:0]                                 m_rdata,
  output logic                                              m_err,
  output logic                                              busy,
  output logic [(N_MASTERS > 1 ? $clog2(N_MASTERS) : 1)-1:0] grant_id
);

  localparam int unsigned GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state;
  logic [GW-1:0]       last_grant;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                lat_write;
  logic [DATA_W-1:0]   rd_data;
  logic                err_flag;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                win_valid;
  logic [GW-1:0]       win_idx;
  int unsigned         cand;
  logic [N_MASTERS-1:0] vbits;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [N_MASTERS-1:0] wbits;

  // Winner search: scan every master once, starting after the last grant.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    vbits     = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
`ifdef BUS_FIXED_PRIORITY_EN
      cand = k;
`else
      cand = (32'(last_grant) + 32'd1 + k) % N_MASTERS;
`endif
      vbits = m_valid >> cand;
      if (!win_valid && vbits[0]) begin
        win_valid = 1'b1;
        win_idx   = GW'(cand);
      end
    end
    sel_addr  = ADDR_W'(m_addr >> (32'(win_idx) * ADDR_W));
    sel_wdata = DATA_W'(m_wdata >> (32'(win_idx) * DATA_W));
    wbits     = m_write >> win_idx;
  end

  // Grant FSM with registered strobes; the register file shares its reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(N_MASTERS - 1);
      grant_id   <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
      rd_data    <= '0;
      err_flag   <= 1'b0;
      m_ready    <= '0;
      m_rvalid   <= '0;
      m_rdata    <= '0;
      m_err      <= 1'b0;
      busy       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[IW'(i)] <= '0;
    end else begin
      m_ready  <= '0;
      m_rvalid <= '0;
      m_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_write  <= wbits[0];
            last_grant <= win_idx;
            grant_id   <= win_idx;
            m_ready    <= N_MASTERS'(1) << win_idx;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (32'(lat_addr) < DEPTH) begin
            err_flag <= 1'b0;
            if (lat_write) mem[IW'(lat_addr)] <= lat_wdata;
            rd_data <= lat_write ? lat_wdata : mem[IW'(lat_addr)];
          end else begin
            // Out-of-range: drop the write, reads return zero.
            err_flag <= 1'b1;
            rd_data  <= lat_write ? lat_wdata : '0;
          end
          state <= RESP;
        end
        RESP: begin
          m_rvalid <= N_MASTERS'(1) << grant_id;
          m_rdata  <= rd_data;
          m_err    <= err_flag;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
